// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM: sequences the shared ALU, unified memory port and register file
// over several cycles per instruction, with a memory ready handshake and a retire counter.
module multi_cycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  OP_i,
  input  logic        Zero_i,
  input  logic        Mem_Ready_i,
  output logic        PC_Write_o,
  output logic        Branch_o,
  output logic        Branch_Taken_o,
  output logic        IR_Write_o,
  output logic        IorD_o,
  output logic        Mem_Read_o,
  output logic        Mem_Write_o,
  output logic        Reg_Write_o,
  output logic [1:0]  ALU_Src_A_o,
  output logic [1:0]  ALU_Src_B_o,
  output logic [2:0]  ALU_Op_o,
  output logic [1:0]  Result_Src_o,
  output logic        Illegal_o,
  output logic [3:0]  State_o,
  output logic [15:0] Instr_Count_o
);

  localparam int unsigned CNT_W = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic pc_write, ir_write, mem_read, mem_write, reg_write, illegal, branch, retire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    illegal      = 1'b0;
    branch       = 1'b0;
    retire       = 1'b0;
    IorD_o       = 1'b0;
    ALU_Src_A_o  = 2'b00;
    ALU_Src_B_o  = 2'b00;
    ALU_Op_o     = 3'b000;
    Result_Src_o = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read     = 1'b1;
        ALU_Src_B_o  = 2'b10;
        ALU_Op_o     = 3'b010;
        Result_Src_o = 2'b10;
        if (Mem_Ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = 3'b010;
        case (OP_i)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LUI:            state_d = S_LUI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = 3'b010;
        state_d     = (OP_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        IorD_o   = 1'b1;
        mem_read = 1'b1;
        if (Mem_Ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        Result_Src_o = 2'b01;
        reg_write    = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD_o    = 1'b1;
        mem_write = 1'b1;
        if (Mem_Ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALU_Src_A_o = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = 3'b001;
        state_d     = S_ALU_WB;
      end
      S_LUI: begin
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = 3'b100;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_Src_A_o = 2'b10;
        ALU_Op_o    = 3'b011;
        branch      = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // Target was computed into ALUOut during DECODE; ALU now forms OldPC+4 for rd.
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b10;
        ALU_Op_o    = 3'b010;
        pc_write    = 1'b1;
        state_d     = S_ALU_WB;
      end
      default: state_d = S_FETCH;
    endcase

    if (retire) count_d = count_q + CNT_W'(1);
  end

  // Write strobes are suppressed while reset is held so an abandoned instruction has no effect.
  assign PC_Write_o     = pc_write  & reset;
  assign IR_Write_o     = ir_write  & reset;
  assign Mem_Read_o     = mem_read  & reset;
  assign Mem_Write_o    = mem_write & reset;
  assign Reg_Write_o    = reg_write & reset;
  assign Illegal_o      = illegal   & reset;
  assign Branch_o       = branch;
  assign Branch_Taken_o = branch & Zero_i;
  assign State_o        = state_q;
  assign Instr_Count_o  = count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control; expectations are hand-derived.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  OP_i;
  logic        Zero_i;
  logic        Mem_Ready_i;
  logic        PC_Write_o, Branch_o, Branch_Taken_o, IR_Write_o, IorD_o;
  logic        Mem_Read_o, Mem_Write_o, Reg_Write_o, Illegal_o;
  logic [1:0]  ALU_Src_A_o, ALU_Src_B_o, Result_Src_o;
  logic [2:0]  ALU_Op_o;
  logic [3:0]  State_o;
  logic [15:0] Instr_Count_o;

  int n_checks = 0;
  int n_bad    = 0;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .Zero_i(Zero_i), .Mem_Ready_i(Mem_Ready_i),
    .PC_Write_o(PC_Write_o), .Branch_o(Branch_o), .Branch_Taken_o(Branch_Taken_o),
    .IR_Write_o(IR_Write_o), .IorD_o(IorD_o), .Mem_Read_o(Mem_Read_o),
    .Mem_Write_o(Mem_Write_o), .Reg_Write_o(Reg_Write_o), .ALU_Src_A_o(ALU_Src_A_o),
    .ALU_Src_B_o(ALU_Src_B_o), .ALU_Op_o(ALU_Op_o), .Result_Src_o(Result_Src_o),
    .Illegal_o(Illegal_o), .State_o(State_o), .Instr_Count_o(Instr_Count_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; OP_i = 7'b0110011; Zero_i = 1'b0; Mem_Ready_i = 1'b1;
    tick(); tick();
    check_eq("init_state", 32'(State_o), 32'd0);
    check_eq("init_count", 32'(Instr_Count_o), 32'd0);
    check_eq("init_mem_read_masked", 32'(Mem_Read_o), 32'd0);
    reset = 1'b1;

    // Start an R-type, then reset in the middle of EXEC_R for two cycles.
    check_eq("pre_fetch_state", 32'(State_o), 32'd0);
    tick(); check_eq("pre_decode_state", 32'(State_o), 32'd1);
    tick(); check_eq("pre_exec_state", 32'(State_o), 32'd6);
    reset = 1'b0;
    check_eq("rst_exec_regwrite", 32'(Reg_Write_o), 32'd0);
    tick();
    check_eq("rst_state", 32'(State_o), 32'd0);
    check_eq("rst_ir_write", 32'(IR_Write_o), 32'd0);
    check_eq("rst_pc_write", 32'(PC_Write_o), 32'd0);
    check_eq("rst_mem_read", 32'(Mem_Read_o), 32'd0);
    check_eq("rst_reg_write", 32'(Reg_Write_o), 32'd0);
    tick();
    reset = 1'b1;
    check_eq("post_rst_state", 32'(State_o), 32'd0);
    check_eq("post_rst_count", 32'(Instr_Count_o), 32'd0);
    #1;
    check_eq("post_rst_mem_read", 32'(Mem_Read_o), 32'd1);

    // R-type: 0,1,6,8,0
    check_eq("r_fetch_irw", 32'(IR_Write_o), 32'd1);
    check_eq("r_fetch_pcw", 32'(PC_Write_o), 32'd1);
    check_eq("r_fetch_srcb", 32'(ALU_Src_B_o), 32'd2);
    check_eq("r_fetch_aluop", 32'(ALU_Op_o), 32'd2);
    check_eq("r_fetch_res", 32'(Result_Src_o), 32'd2);
    tick();
    check_eq("r_decode_state", 32'(State_o), 32'd1);
    check_eq("r_decode_srca", 32'(ALU_Src_A_o), 32'd1);
    check_eq("r_decode_srcb", 32'(ALU_Src_B_o), 32'd1);
    tick();
    check_eq("r_exec_state", 32'(State_o), 32'd6);
    check_eq("r_exec_aluop", 32'(ALU_Op_o), 32'd0);
    check_eq("r_exec_srca", 32'(ALU_Src_A_o), 32'd2);
    check_eq("r_exec_regw", 32'(Reg_Write_o), 32'd0);
    tick();
    check_eq("r_wb_state", 32'(State_o), 32'd8);
    check_eq("r_wb_regw", 32'(Reg_Write_o), 32'd1);
    check_eq("r_wb_res", 32'(Result_Src_o), 32'd0);
    tick();
    check_eq("r_done_state", 32'(State_o), 32'd0);
    check_eq("r_done_count", 32'(Instr_Count_o), 32'd1);

    // LOAD with three wait cycles in MEM_READ: 0,1,2,3,3,3,3,4,0
    OP_i = 7'b0000011;
    tick(); check_eq("ld_decode", 32'(State_o), 32'd1);
    tick(); check_eq("ld_addr", 32'(State_o), 32'd2);
    check_eq("ld_addr_srca", 32'(ALU_Src_A_o), 32'd2);
    check_eq("ld_addr_srcb", 32'(ALU_Src_B_o), 32'd1);
    Mem_Ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ld_wait_state", 32'(State_o), 32'd3);
      check_eq("ld_wait_rd", 32'(Mem_Read_o), 32'd1);
      check_eq("ld_wait_iord", 32'(IorD_o), 32'd1);
    end
    tick();
    check_eq("ld_last_read", 32'(State_o), 32'd3);
    Mem_Ready_i = 1'b1;
    tick();
    check_eq("ld_wb_state", 32'(State_o), 32'd4);
    check_eq("ld_wb_res", 32'(Result_Src_o), 32'd1);
    check_eq("ld_wb_regw", 32'(Reg_Write_o), 32'd1);
    tick();
    check_eq("ld_done_state", 32'(State_o), 32'd0);
    check_eq("ld_done_count", 32'(Instr_Count_o), 32'd2);

    // STORE: 0,1,2,5,0
    OP_i = 7'b0100011;
    tick(); tick();
    check_eq("st_addr", 32'(State_o), 32'd2);
    tick();
    check_eq("st_write_state", 32'(State_o), 32'd5);
    check_eq("st_mem_write", 32'(Mem_Write_o), 32'd1);
    check_eq("st_iord", 32'(IorD_o), 32'd1);
    check_eq("st_mem_read", 32'(Mem_Read_o), 32'd0);
    tick();
    check_eq("st_done_state", 32'(State_o), 32'd0);
    check_eq("st_done_memw", 32'(Mem_Write_o), 32'd0);
    check_eq("st_done_count", 32'(Instr_Count_o), 32'd3);

    // BRANCH with Zero_i=1: 0,1,9,0
    OP_i = 7'b1100011; Zero_i = 1'b1;
    tick(); tick();
    check_eq("br_state", 32'(State_o), 32'd9);
    check_eq("br_branch", 32'(Branch_o), 32'd1);
    check_eq("br_taken", 32'(Branch_Taken_o), 32'd1);
    check_eq("br_aluop", 32'(ALU_Op_o), 32'd3);
    tick();
    check_eq("br_done_state", 32'(State_o), 32'd0);
    check_eq("br_done_count", 32'(Instr_Count_o), 32'd4);
    Zero_i = 1'b0;

    // JAL: 0,1,10,8,0
    OP_i = 7'b1101111;
    check_eq("jal_fetch_pcw", 32'(PC_Write_o), 32'd1);
    tick(); tick();
    check_eq("jal_state", 32'(State_o), 32'd10);
    check_eq("jal_pcw", 32'(PC_Write_o), 32'd1);
    check_eq("jal_srca", 32'(ALU_Src_A_o), 32'd1);
    check_eq("jal_srcb", 32'(ALU_Src_B_o), 32'd2);
    check_eq("jal_regw", 32'(Reg_Write_o), 32'd0);
    tick();
    check_eq("jal_wb_state", 32'(State_o), 32'd8);
    check_eq("jal_wb_regw", 32'(Reg_Write_o), 32'd1);
    check_eq("jal_wb_res", 32'(Result_Src_o), 32'd0);
    check_eq("jal_wb_pcw", 32'(PC_Write_o), 32'd0);
    tick();
    check_eq("jal_done_count", 32'(Instr_Count_o), 32'd5);

    // Illegal opcode: 0,1(Illegal),0 with count unchanged
    OP_i = 7'b1111111;
    tick();
    check_eq("ill_decode_state", 32'(State_o), 32'd1);
    check_eq("ill_pulse", 32'(Illegal_o), 32'd1);
    tick();
    check_eq("ill_next_state", 32'(State_o), 32'd0);
    check_eq("ill_pulse_gone", 32'(Illegal_o), 32'd0);
    check_eq("ill_count", 32'(Instr_Count_o), 32'd5);

    // Fetch stall: strobes held, no IR/PC load until ready
    Mem_Ready_i = 1'b0;
    #1;
    check_eq("stall_irw", 32'(IR_Write_o), 32'd0);
    check_eq("stall_pcw", 32'(PC_Write_o), 32'd0);
    check_eq("stall_rd", 32'(Mem_Read_o), 32'd1);
    tick();
    check_eq("stall_state", 32'(State_o), 32'd0);

    // Counter wrap: preload 0xFFFF, retire one BRANCH
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    #1;
    check_eq("wrap_preload", 32'(Instr_Count_o), 32'hFFFF);
    Mem_Ready_i = 1'b1; OP_i = 7'b1100011;
    tick(); tick();
    check_eq("wrap_br_state", 32'(State_o), 32'd9);
    check_eq("wrap_br_taken", 32'(Branch_Taken_o), 32'd0);
    tick();
    check_eq("wrap_count", 32'(Instr_Count_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
